bcd_2dig_display: RTL and testbench

//  Consumes the tens/units digit pair produced by the BCD adder stage and drives a
//  2-digit multiplexed 7-segment display. Latches the digit pair on a load strobe,

---
 rtl/bcd_2dig_display.sv | 139 +++++++++++++
 tb/tb_bcd_2dig_display.sv | 122 ++++++++++++
 2 files changed

// File: rtl/bcd_2dig_display.sv
// Two-digit multiplexed 7-segment driver: latches a BCD digit pair and scans units/tens with blanking gaps.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank the tens slot when the tens digit is 0).
module bcd_2dig_display #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] dig_u,
  input  logic [3:0] dig_d,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UNITS = 3'd1,
    S_GAP_U = 3'd2,
    S_TENS  = 3'd3,
    S_GAP_T = 3'd4
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(REFRESH_DIV - 1);

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [3:0]  reg_u_r, reg_d_r;
  logic [6:0]  seg_s;
  logic [1:0]  an_s;

  function automatic logic [6:0] enc(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'd0:    r = 7'b0111111;
      4'd1:    r = 7'b0000110;
      4'd2:    r = 7'b1011011;
      4'd3:    r = 7'b1001111;
      4'd4:    r = 7'b1100110;
      4'd5:    r = 7'b1101101;
      4'd6:    r = 7'b1111101;
      4'd7:    r = 7'b0000111;
      4'd8:    r = 7'b1111111;
      4'd9:    r = 7'b1101111;
      default: r = 7'b1111001;
    endcase
    return r;
  endfunction

  // State and slot counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and counter logic; GAP states last exactly one cycle
  always_comb begin
    state_s = state_r;
    cnt_s   = 16'd0;
    case (state_r)
      S_IDLE:  state_s = S_UNITS;
      S_UNITS: begin
        if (cnt_r == CNT_LAST) begin
          state_s = S_GAP_U;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      S_GAP_U: state_s = S_TENS;
      S_TENS: begin
        if (cnt_r == CNT_LAST) begin
          state_s = S_GAP_T;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      S_GAP_T: state_s = S_UNITS;
      default: state_s = S_IDLE;
    endcase
  end

  // Display drive decoded from the current state and digit registers
  always_comb begin
    seg_s = 7'd0;
    an_s  = 2'b00;
    case (state_r)
      S_UNITS: begin
        an_s  = 2'b01;
        seg_s = enc(reg_u_r);
      end
      S_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (reg_d_r == 4'd0) begin
          an_s  = 2'b00;
          seg_s = 7'd0;
        end else begin
          an_s  = 2'b10;
          seg_s = enc(reg_d_r);
        end
`else
        an_s  = 2'b10;
        seg_s = enc(reg_d_r);
`endif
      end
      default: begin
        an_s  = 2'b00;
        seg_s = 7'd0;
      end
    endcase
  end

  // Digit capture and registered display outputs; load never affects the scan
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_u_r <= 4'd0;
      reg_d_r <= 4'd0;
      seg     <= 7'd0;
      an      <= 2'b00;
    end else begin
      if (load) begin
        reg_u_r <= dig_u;
        reg_d_r <= dig_d;
      end else begin
        reg_u_r <= reg_u_r;
        reg_d_r <= reg_d_r;
      end
      seg <= seg_s;
      an  <= an_s;
    end
  end

  assign err = (reg_u_r > 4'd9) | (reg_d_r > 4'd9);

endmodule

// File: tb/tb_bcd_2dig_display.sv
// Randomized and directed bench for bcd_2dig_display against a cycle-position reference model.
module tb_bcd_2dig_display;
  localparam int R = 4;
  localparam int P = 2 * R + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] dig_u = 4'd0;
  logic [3:0] dig_d = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  int n_checks = 0;
  int n_fail = 0;
  int ecount = 0;
  int m_u = 0;
  int m_d = 0;
  logic [6:0] enc_tab [16];

  bcd_2dig_display #(.REFRESH_DIV(R)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .dig_u(dig_u), .dig_d(dig_d),
    .seg(seg), .an(an), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, obs, exp, ecount, $time);
    end
  endtask

  // Position in the scan that the NEXT edge will register (edges counted since reset release)
  function automatic int next_pos();
    return (ecount + 1 - 2) % P;
  endfunction

  // One clock: apply inputs, advance the model, compare outputs after the edge
  task automatic cyc(input logic r, input logic l, input int u, input int d);
    int exp_an;
    int exp_seg;
    int p;
    rst_n = r;
    load  = l;
    dig_u = 4'(u);
    dig_d = 4'(d);
    @(posedge clk);
    #1;
    exp_an = 0;
    exp_seg = 0;
    if (!r) begin
      ecount = 0;
      m_u = 0;
      m_d = 0;
    end else begin
      ecount++;
      if (ecount >= 2) begin
        p = (ecount - 2) % P;
        if (p < R) begin
          exp_an = 1;
          exp_seg = int'(enc_tab[m_u]);
        end else if (p > R && p < 2 * R + 1) begin
`ifdef LEADING_ZERO_BLANK_EN
          if (m_d != 0) begin
            exp_an = 2;
            exp_seg = int'(enc_tab[m_d]);
          end
`else
          exp_an = 2;
          exp_seg = int'(enc_tab[m_d]);
`endif
        end
      end
      if (l) begin
        m_u = u;
        m_d = d;
      end
    end
    check("an", int'(an), exp_an);
    check("seg", int'(seg), exp_seg);
    check("err", int'(err), ((m_u > 9) || (m_d > 9)) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    enc_tab[0] = 7'b0111111; enc_tab[1] = 7'b0000110; enc_tab[2] = 7'b1011011;
    enc_tab[3] = 7'b1001111; enc_tab[4] = 7'b1100110; enc_tab[5] = 7'b1101101;
    enc_tab[6] = 7'b1111101; enc_tab[7] = 7'b0000111; enc_tab[8] = 7'b1111111;
    enc_tab[9] = 7'b1101111;
    for (int i = 10; i < 16; i++) enc_tab[i] = 7'b1111001;

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0, 0);
    idle(3);
    cyc(1'b1, 1'b1, 7, 1);
    idle(3 * P);
    cyc(1'b1, 1'b1, 12, 3);
    idle(P + 2);
    cyc(1'b1, 1'b1, 4, 3);
    idle(P + 2);
    cyc(1'b1, 1'b1, 5, 0);
    idle(P + 2);
    while (next_pos() != R - 1) cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 2, 8);
    idle(P + 2);
    while (next_pos() != R + 2) cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 0, 0);
    idle(P + 3);
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
